// File: rtl/perm_arb.sv
// perm_arb: round-robin arbiter feeding 8-beat jobs from two requesters into a
// permutation core and routing its 8 output beats back as tagged responses.
module perm_arb #(
    parameter int WAIT_MAX = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   r_valid,
    output logic [1:0]   r_ready,
    input  logic [199:0] r0_din,
    input  logic [199:0] r1_din,
    output logic         p_pushin,
    output logic [2:0]   p_dix,
    output logic [199:0] p_din,
    input  logic         p_pushout,
    input  logic [2:0]   p_doutix,
    input  logic [199:0] p_dout,
    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [2:0]   rsp_ix,
    output logic [199:0] rsp_data,
    output logic         busy,
    output logic         err
);
    localparam int TW = $clog2(WAIT_MAX + 1);
    typedef enum logic [1:0] {IDLE, LOAD, WAIT, DRAIN} state_t;
    state_t state, state_nx;
    logic g, last, g_nx, beat, out_beat, timeout, draining;
    logic [2:0] cnt, ocnt;
    logic [TW-1:0] tmr;
    always_comb begin
        draining = (state == WAIT) || (state == DRAIN);
        g_nx     = (r_valid == 2'b11) ? ~last : r_valid[1];
        r_ready  = (state == LOAD) ? (g ? 2'b10 : 2'b01) : 2'b00;
        beat     = (state == LOAD) && r_valid[g];
        p_pushin = beat;
        p_dix    = cnt;
        p_din    = beat ? (g ? r1_din : r0_din) : '0;
        out_beat = p_pushout && draining;
        // tmr counts consecutive idle cycles; the last allowed one ends the job
        timeout  = draining && !p_pushout && (tmr == TW'(WAIT_MAX - 1));
        busy     = state != IDLE;
        state_nx = state;
        case (state)
            IDLE:    state_nx = |r_valid ? LOAD : IDLE;
            LOAD:    state_nx = (beat && cnt == 3'd7) ? WAIT : LOAD;
            WAIT:    state_nx = out_beat ? DRAIN : (timeout ? IDLE : WAIT);
            DRAIN:   state_nx = ((out_beat && ocnt == 3'd7) || timeout) ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            g         <= 1'b0;
            last      <= 1'b1;
            cnt       <= '0;
            ocnt      <= '0;
            tmr       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_ix    <= '0;
            rsp_data  <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && |r_valid) begin
                g    <= g_nx;
                last <= g_nx;
            end
            if (beat) cnt <= cnt + 3'd1;
            ocnt      <= (state == IDLE) ? 3'd0 : (out_beat ? ocnt + 3'd1 : ocnt);
            tmr       <= (out_beat || !draining) ? '0 : tmr + 1'b1;
            rsp_valid <= out_beat;
            if (out_beat) begin
                rsp_id   <= g;
                rsp_ix   <= p_doutix;
                rsp_data <= p_dout;
            end
            if ((p_pushout && !draining) || (out_beat && p_doutix != ocnt) || timeout) err <= 1'b1;
        end
    end
endmodule
